// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, decoded byte and status strobes out.
// The receiver uses the slave view; the line driver/consumer uses the master view.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (output rx, input data, rx_valid, frame_err, busy);
  modport slave  (input rx, output data, rx_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, oversampling tick generator and frame FSM.
// Emits each good byte with a 1-cycle rx_valid, and a 1-cycle frame_err on a low stop bit.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | timing to mid start bit, rejects glitches
// DATA  | sampling 8 data bits at mid bit, LSB first
// STOP  | sampling the stop bit
// BRK   | stop bit was low, waiting for the line to go high
module uart_rx_core #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_MID    = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t           state, state_n;
  logic             rx_m, rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick, clr_tick;
  logic [S_W-1:0]   s_cnt, s_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       data_n;
  logic             valid_n, ferr_n, busy_n;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
    end
  end

  // Clearing on start detect aligns the sampling phase to the start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  div_cnt <= '0;
    else if (clr_tick || tick) div_cnt <= '0;
    else                      div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      s_cnt         <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      bus.data      <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state         <= state_n;
      s_cnt         <= s_cnt_n;
      bit_idx       <= bit_idx_n;
      shreg         <= shreg_n;
      bus.data      <= data_n;
      bus.rx_valid  <= valid_n;
      bus.frame_err <= ferr_n;
      bus.busy      <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    s_cnt_n   = s_cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    data_n    = bus.data;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    busy_n    = bus.busy;
    clr_tick  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n  = START;
          s_cnt_n  = '0;
          clr_tick = 1'b1;
          busy_n   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt == S_MID) begin
            s_cnt_n = '0;
            if (!rx_s) begin
              state_n   = DATA;
              bit_idx_n = '0;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt == S_LAST) begin
            s_cnt_n   = '0;
            shreg_n   = {rx_s, shreg[7:1]};
            bit_idx_n = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_n = STOP;
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_cnt == S_LAST) begin
            s_cnt_n = '0;
            if (rx_s) begin
              data_n  = shreg;
              valid_n = 1'b1;
              state_n = IDLE;
              busy_n  = 1'b0;
            end else begin
              ferr_n  = 1'b1;
              state_n = BRK;
            end
          end else begin
            s_cnt_n = s_cnt + 1'b1;
          end
        end
      end
      // A held-low line must not be re-read as a stream of zero frames.
      BRK: begin
        if (rx_s) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        s_cnt_n = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core at 16 clocks per bit: a line driver, a strobe monitor and an
// expected-event queue built from the bytes and stop bits that were put on the line.
module tb_uart_rx_core;

  localparam int OS     = 16;
  localparam int CLK_NS = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  uart_rx_if bus();

  uart_rx_core #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(OS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #(CLK_NS/2) clk = ~clk;

  // observed strobes (kind 0 = byte, 1 = framing error)
  bit         ev_kind[$];
  logic [7:0] ev_data[$];
  time        ev_t[$];
  int         overlap = 0;
  int         longp   = 0;
  logic       prev_v = 1'b0, prev_f = 1'b0;

  // reference model: what the line carried
  bit         exp_kind[$];
  logic [7:0] exp_data[$];
  logic [7:0] exp_hold = 8'h00;
  time        start_t;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      ev_kind.push_back(1'b0); ev_data.push_back(bus.data); ev_t.push_back($time);
    end
    if (bus.frame_err === 1'b1) begin
      ev_kind.push_back(1'b1); ev_data.push_back(bus.data); ev_t.push_back($time);
    end
    if (bus.rx_valid === 1'b1 && bus.frame_err === 1'b1) overlap++;
    if ((bus.rx_valid === 1'b1 && prev_v) || (bus.frame_err === 1'b1 && prev_f)) longp++;
    prev_v = (bus.rx_valid === 1'b1);
    prev_f = (bus.frame_err === 1'b1);
  end

  task automatic drive_bit(input logic b, input int per);
    bus.rx = b;
    repeat (per) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
    if (stop) begin
      exp_kind.push_back(1'b0); exp_data.push_back(b); exp_hold = b;
    end else begin
      exp_kind.push_back(1'b1); exp_data.push_back(exp_hold);
    end
    start_t = $time;
    drive_bit(1'b0, per);
    for (int i = 0; i < 8; i++) drive_bit(b[i], per);
    drive_bit(stop, per);
  endtask

  task automatic flush_queues();
    ev_kind.delete(); ev_data.delete(); ev_t.delete();
    exp_kind.delete(); exp_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst = 1'b0;
    drive_bit(1'b1, 10);
  endtask

  task automatic test_single();
    time lat;
    flush_queues();
    send_frame(8'hA5, 1'b1, OS);
    drive_bit(1'b1, 30);
    lat = (2 + 1 + OS/2 + 9*OS) * CLK_NS;
    checks++;
    if (ev_kind.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d events want 1", ev_kind.size());
    end else begin
      checks++; if (ev_kind[0] !== 1'b0 || ev_data[0] !== 8'hA5) begin
        errors++; $display("FAIL single_byte: got kind %0d data %h want kind 0 data a5", ev_kind[0], ev_data[0]);
      end
      checks++; if (ev_t[0] - start_t !== lat) begin
        errors++; $display("FAIL single_latency: got %0t want %0t", ev_t[0] - start_t, lat);
      end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", bus.busy); end
    checks++; if (bus.data !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h want a5", bus.data); end
  endtask

  task automatic test_back_to_back();
    int n;
    flush_queues();
    send_frame(8'h00, 1'b1, OS);
    send_frame(8'hFF, 1'b1, OS);
    for (int k = 0; k < 8; k++) begin
      send_frame(8'($urandom), 1'b1, OS);
      n = $urandom_range(0, 3);
      if (n != 0) drive_bit(1'b1, n);
    end
    drive_bit(1'b1, 30);
    checks++;
    if (ev_kind.size() != exp_kind.size()) begin
      errors++; $display("FAIL b2b_count: got %0d events want %0d", ev_kind.size(), exp_kind.size());
    end else begin
      for (int i = 0; i < exp_kind.size(); i++) begin
        checks++;
        if (ev_kind[i] !== exp_kind[i] || ev_data[i] !== exp_data[i]) begin
          errors++; $display("FAIL b2b_event%0d: got kind %0d data %h want kind %0d data %h",
                             i, ev_kind[i], ev_data[i], exp_kind[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    flush_queues();
    drive_bit(1'b0, 4);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b want 1", bus.busy); end
    drive_bit(1'b1, 30);
    checks++; if (ev_kind.size() != 0) begin errors++; $display("FAIL glitch_events: got %0d want 0", ev_kind.size()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b want 0", bus.busy); end
    checks++; if (bus.data !== exp_hold) begin errors++; $display("FAIL glitch_data: got %h want %h", bus.data, exp_hold); end
  endtask

  task automatic test_frame_err();
    logic [7:0] b;
    flush_queues();
    send_frame(8'h3C, 1'b0, OS);
    drive_bit(1'b0, 40);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_break: got %b want 1", bus.busy); end
    drive_bit(1'b1, 40);
    checks++;
    if (ev_kind.size() != 1) begin
      errors++; $display("FAIL ferr_count: got %0d events want 1", ev_kind.size());
    end else begin
      checks++; if (ev_kind[0] !== 1'b1) begin errors++; $display("FAIL ferr_kind: got %0d want 1", ev_kind[0]); end
    end
    checks++; if (bus.data !== exp_hold) begin errors++; $display("FAIL ferr_data: got %h want %h", bus.data, exp_hold); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_idle: got %b want 0", bus.busy); end
    flush_queues();
    b = 8'($urandom);
    send_frame(b, 1'b1, OS);
    drive_bit(1'b1, 30);
    checks++;
    if (ev_kind.size() != 1 || ev_kind[0] !== 1'b0 || ev_data[0] !== b) begin
      errors++; $display("FAIL ferr_recover: got %0d events want one byte %h", ev_kind.size(), b);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    flush_queues();
    b = 8'h55;
    drive_bit(1'b0, OS);
    for (int i = 0; i < 4; i++) drive_bit(b[i], OS);
    drive_bit(b[4], OS/2);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.data !== 8'h00 || bus.rx_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got data %h v %b f %b busy %b want all 0",
                         bus.data, bus.rx_valid, bus.frame_err, bus.busy);
    end
    bus.rx = 1'b1;
    rst = 1'b0;
    exp_hold = 8'h00;
    drive_bit(1'b1, 20);
    checks++; if (ev_kind.size() != 0) begin errors++; $display("FAIL midreset_partial: got %0d events want 0", ev_kind.size()); end
    send_frame(8'h81, 1'b1, OS);
    drive_bit(1'b1, 30);
    checks++;
    if (ev_kind.size() != 1 || ev_kind[0] !== 1'b0 || ev_data[0] !== 8'h81) begin
      errors++; $display("FAIL midreset_next: got %0d events want one byte 81", ev_kind.size());
    end
    checks++; if (bus.data !== 8'h81) begin errors++; $display("FAIL midreset_data: got %h want 81", bus.data); end
  endtask

  task automatic test_skew();
    int pers[2] = '{15, 17};
    for (int p = 0; p < 2; p++) begin
      flush_queues();
      bus.rx = 1'b1;
      send_frame(8'hC3, 1'b1, pers[p]);
      drive_bit(1'b1, 40);
      checks++;
      if (ev_kind.size() != 1 || ev_kind[0] !== 1'b0 || ev_data[0] !== 8'hC3) begin
        errors++; $display("FAIL skew_%0d: got %0d events data %h want one byte c3",
                           pers[p], ev_kind.size(), (ev_data.size() > 0) ? ev_data[0] : 8'hxx);
      end
    end
  endtask

  task automatic test_strobes();
    checks++; if (overlap != 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", overlap); end
    checks++; if (longp != 0) begin errors++; $display("FAIL strobe_width: got %0d long pulses want 0", longp); end
  endtask

  initial begin
    bus.rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_skew();
    test_strobes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(60_000 * CLK_NS);
    $display("FAIL timeout: simulation exceeded 60000 cycles");
    $fatal(1, "timeout");
  end

endmodule
